mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mdu_pkg.sv | 65 ++++++
 rtl/mdu_if.sv | 30 +++
 rtl/mdu_counter.sv | 39 +++
 rtl/mult_div_unit.sv | 174 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_pkg
//  Purpose  : Shared definitions for the multiply/divide unit. Holds the
//             op-code map, the FSM state encoding, the default busy
//             latencies and an op-class decoder.
//  Revision : 1.0  initial release
// ============================================================================
package mdu_pkg;

    // Default busy latencies
    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    // Operation codes. Values 11-15 are unused and behave as NONE.
    localparam logic [3:0] c_OP_NONE  = 4'd0;
    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MTHI  = 4'd5;
    localparam logic [3:0] c_OP_MTLO  = 4'd6;
    localparam logic [3:0] c_OP_MADD  = 4'd7;
    localparam logic [3:0] c_OP_MADDU = 4'd8;
    localparam logic [3:0] c_OP_MSUB  = 4'd9;
    localparam logic [3:0] c_OP_MSUBU = 4'd10;

    // FSM state encoding
    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_MULT_RUN = 2'd1;
    localparam logic [1:0] c_ST_DIV_RUN  = 2'd2;

    // Decoded op class; an all-zero value means "not an MDU op".
    typedef struct packed {
        logic mul;   // multiply-class, runs in MULT_RUN
        logic div;   // divide-class, runs in DIV_RUN
        logic mthi;  // single-edge write of hi
        logic mtlo;  // single-edge write of lo
        logic acc;   // accumulate into {hi,lo}
        logic sub;   // accumulate by subtraction
        logic sgn;   // signed operands
    } op_class_t;

    // Accumulate ops decode as NONE unless madd_en is set.
    function automatic op_class_t decode_op(input logic [3:0] op, input logic madd_en);
        op_class_t c;
        c = '0;
        case (op)
            c_OP_MULT:  begin c.mul = 1'b1; c.sgn = 1'b1; end
            c_OP_MULTU: begin c.mul = 1'b1; end
            c_OP_DIV:   begin c.div = 1'b1; c.sgn = 1'b1; end
            c_OP_DIVU:  begin c.div = 1'b1; end
            c_OP_MTHI:  begin c.mthi = 1'b1; end
            c_OP_MTLO:  begin c.mtlo = 1'b1; end
            c_OP_MADD:  begin c.mul = madd_en; c.acc = madd_en; c.sgn = madd_en; end
            c_OP_MADDU: begin c.mul = madd_en; c.acc = madd_en; end
            c_OP_MSUB:  begin c.mul = madd_en; c.acc = madd_en; c.sub = madd_en; c.sgn = madd_en; end
            c_OP_MSUBU: begin c.mul = madd_en; c.acc = madd_en; c.sub = madd_en; end
            default:    c = '0;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_if.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_if
//  Purpose  : E-stage <-> multiply/divide unit bundle.
//  Ports    : start, op, rs_data, rt_data, req  (issue side, from E stage)
//             busy, hi, lo                      (unit status and results)
//  Modports : master = E stage, slave = mult_div_unit
//  Revision : 1.0  initial release
// ============================================================================
interface mdu_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        req;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_data, rt_data, req,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, req,
        output busy, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/mdu_counter.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_counter
//  Purpose  : Loadable down-counter. done is high while the count is 1,
//             i.e. during the last cycle of a run, so the owner commits on
//             the edge that takes the count to 0.
//  Ports    : clk, rst_n (async, active-low)
//             load, load_val : load a new count (has priority)
//             en             : decrement while nonzero
//             done           : count == 1
//  Revision : 1.0  initial release
// ============================================================================
module mdu_counter #(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_val,
    input  wire logic             en,
    output logic                  done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign done = (r_count == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mult_div_unit
//  Purpose  : Multi-cycle HI/LO multiply/divide unit for the E stage.
//             Operands are latched on issue; the result is committed to
//             hi/lo on the same edge that drops busy.
//  Ports    : clk, rst_n (async, active-low)
//             bus (mdu_if.slave): start, op, rs_data, rt_data, req -> in
//                                 busy, hi, lo                     -> out
//  Params   : MULT_CYCLES, DIV_CYCLES  busy cycles per op class
//  Config   : define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU; when
//             undefined those op codes behave as NONE.
//  Revision : 1.0  initial release
// ============================================================================
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  wire logic clk,
    input  wire logic rst_n,
    mdu_if.slave      bus
);

`ifdef MDU_MADD_EN
    localparam logic c_MADD_EN = 1'b1;
`else
    localparam logic c_MADD_EN = 1'b0;
`endif

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W        = $clog2(c_MAX_CYCLES + 1);

    logic [1:0]  r_state;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_sgn;
    logic        r_acc;
    logic        r_sub;

    op_class_t   w_cls;
    logic        w_busy;
    logic        w_accept;
    logic        w_load;
    logic        w_done;

    // ------------------------------------------------------------------
    // Issue decode
    // ------------------------------------------------------------------
    assign w_cls    = decode_op(bus.op, c_MADD_EN);
    assign w_busy   = (r_state != c_ST_IDLE);
    assign w_accept = bus.start && !w_busy && !bus.req &&
                      (w_cls.mul || w_cls.div || w_cls.mthi || w_cls.mtlo);
    assign w_load   = w_accept && (w_cls.mul || w_cls.div);

    mdu_counter #(
        .WIDTH (CNT_W)
    ) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (w_cls.div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES)),
        .en       (w_busy),
        .done     (w_done)
    );

    // ------------------------------------------------------------------
    // Multiply / accumulate datapath (from latched operands)
    // ------------------------------------------------------------------
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_prod;
    logic [63:0] w_acc_base;
    logic [63:0] w_mul_res;

    // Sign- or zero-extend to 64 bits; the low 64 bits of the product are
    // then correct for both signed and unsigned operands.
    assign w_a_ext    = {{32{r_sgn & r_a[31]}}, r_a};
    assign w_b_ext    = {{32{r_sgn & r_b[31]}}, r_b};
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_acc_base = r_acc ? {r_hi, r_lo} : 64'd0;
    assign w_mul_res  = r_sub ? (w_acc_base - w_prod) : (w_acc_base + w_prod);

    // ------------------------------------------------------------------
    // Divide datapath: unsigned divide on magnitudes, then fix up signs
    // (quotient truncates toward zero, remainder follows the dividend).
    // ------------------------------------------------------------------
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_den;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_div_hi;
    logic [31:0] w_div_lo;

    assign w_a_neg = r_sgn & r_a[31];
    assign w_b_neg = r_sgn & r_b[31];
    assign w_a_mag = w_a_neg ? (32'd0 - r_a) : r_a;
    assign w_b_mag = w_b_neg ? (32'd0 - r_b) : r_b;
    // Keep the divider defined on a zero divisor; that case is overridden.
    assign w_den   = (r_b == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag = w_a_mag / w_den;
    assign w_r_mag = w_a_mag % w_den;

    always_comb begin
        w_div_hi = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;
        w_div_lo = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
        if (r_b == 32'd0) begin
            w_div_hi = r_a;
            w_div_lo = 32'hFFFF_FFFF;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and HI/LO registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_sgn   <= 1'b0;
            r_acc   <= 1'b0;
            r_sub   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        if (w_cls.mthi) begin
                            r_hi <= bus.rs_data;
                        end else if (w_cls.mtlo) begin
                            r_lo <= bus.rs_data;
                        end else begin
                            r_a     <= bus.rs_data;
                            r_b     <= bus.rt_data;
                            r_sgn   <= w_cls.sgn;
                            r_acc   <= w_cls.acc;
                            r_sub   <= w_cls.sub;
                            r_state <= w_cls.div ? c_ST_DIV_RUN : c_ST_MULT_RUN;
                        end
                    end
                end
                c_ST_MULT_RUN: begin
                    if (w_done) begin
                        r_hi    <= w_mul_res[63:32];
                        r_lo    <= w_mul_res[31:0];
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_DIV_RUN: begin
                    if (w_done) begin
                        r_hi    <= w_div_hi;
                        r_lo    <= w_div_lo;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign bus.busy = w_busy;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_div_unit
//  Purpose  : Self-checking bench for mult_div_unit: directed vector table
//             plus hand-written sequences for cancel, busy-start and reset
//             abort. Expectations follow MDU_MADD_EN when it is defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mdu_if u_if();

    mult_div_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cyc;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input string name, input logic [3:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] eh, input logic [31:0] el,
                                input int cyc);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b;
        v.exp_hi = eh; v.exp_lo = el; v.exp_cyc = cyc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op, scramble the inputs right after the issue edge, and
    // count edges until busy drops (bounded).
    task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int cyc);
        @(negedge clk);
        u_if.start = 1'b1; u_if.op = op; u_if.rs_data = a; u_if.rt_data = b; u_if.req = 1'b0;
        @(posedge clk); #1;
        u_if.start = 1'b0; u_if.op = c_OP_DIVU;
        u_if.rs_data = $urandom; u_if.rt_data = $urandom;
        cyc = 0;
        while (u_if.busy && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        logic [31:0] hold_hi, hold_lo;

        u_if.start = 1'b0; u_if.op = c_OP_NONE; u_if.req = 1'b0;
        u_if.rs_data = 32'd0; u_if.rt_data = 32'd0;

        // ---------------- reset state ----------------
        #3;
        check("reset_busy", {31'd0, u_if.busy}, 32'd0);
        check("reset_hi", u_if.hi, 32'd0);
        check("reset_lo", u_if.lo, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // ---------------- vector table ----------------
        vq.push_back(mk("mult_neg",   c_OP_MULT,  32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5));
        vq.push_back(mk("multu_big",  c_OP_MULTU, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, 5));
        vq.push_back(mk("div_neg",    c_OP_DIV,   32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10));
        vq.push_back(mk("divu_zero",  c_OP_DIVU,  32'h7, 32'h0, 32'h00000007, 32'hFFFFFFFF, 10));
        vq.push_back(mk("div_negdiv", c_OP_DIV,   32'h7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10));
        vq.push_back(mk("divu_basic", c_OP_DIVU,  32'd100, 32'd7, 32'h2, 32'hE, 10));
        vq.push_back(mk("div_zero",   c_OP_DIV,   32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF, 10));
        vq.push_back(mk("mult_carry", c_OP_MULT,  32'h00010000, 32'h00010000, 32'h1, 32'h0, 5));
        vq.push_back(mk("mult_2neg",  c_OP_MULT,  32'hFFFFFFFD, 32'hFFFFFFFB, 32'h0, 32'hF, 5));
        vq.push_back(mk("multu_msb",  c_OP_MULTU, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 5));
        vq.push_back(mk("mthi",       c_OP_MTHI,  32'hDEADBEEF, 32'h5, 32'hDEADBEEF, 32'h0, 0));
        vq.push_back(mk("mtlo",       c_OP_MTLO,  32'h12345678, 32'h5, 32'hDEADBEEF, 32'h12345678, 0));
        vq.push_back(mk("op_none",    c_OP_NONE,  32'h1, 32'h1, 32'hDEADBEEF, 32'h12345678, 0));
        vq.push_back(mk("op_13",      4'd13,      32'h1, 32'h1, 32'hDEADBEEF, 32'h12345678, 0));
        vq.push_back(mk("mthi_zero",  c_OP_MTHI,  32'h0, 32'h0, 32'h0, 32'h12345678, 0));
        vq.push_back(mk("mtlo_ones",  c_OP_MTLO,  32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFF, 0));
`ifdef MDU_MADD_EN
        vq.push_back(mk("maddu",      c_OP_MADDU, 32'h1, 32'h1, 32'h1, 32'h0, 5));
        vq.push_back(mk("msub",       c_OP_MSUB,  32'h2, 32'h3, 32'h0, 32'hFFFFFFFA, 5));
        vq.push_back(mk("madd_neg",   c_OP_MADD,  32'hFFFFFFFF, 32'h1, 32'h0, 32'hFFFFFFF9, 5));
`else
        vq.push_back(mk("maddu_off",  c_OP_MADDU, 32'h1, 32'h1, 32'h0, 32'hFFFFFFFF, 0));
        vq.push_back(mk("msub_off",   c_OP_MSUB,  32'h2, 32'h3, 32'h0, 32'hFFFFFFFF, 0));
        vq.push_back(mk("madd_off",   c_OP_MADD,  32'hFFFFFFFF, 32'h1, 32'h0, 32'hFFFFFFFF, 0));
`endif

        foreach (vq[i]) begin
            run_op(vq[i].op, vq[i].a, vq[i].b, cyc);
            check({vq[i].name, "_cycles"}, 32'(cyc), 32'(vq[i].exp_cyc));
            check({vq[i].name, "_hi"}, u_if.hi, vq[i].exp_hi);
            check({vq[i].name, "_lo"}, u_if.lo, vq[i].exp_lo);
        end

        // ---------------- req cancels a same-cycle start ----------------
        hold_hi = u_if.hi; hold_lo = u_if.lo;
        @(negedge clk);
        u_if.start = 1'b1; u_if.op = c_OP_MULT; u_if.rs_data = 32'h3; u_if.rt_data = 32'h3; u_if.req = 1'b1;
        @(posedge clk); #1;
        u_if.start = 1'b0; u_if.req = 1'b0;
        check("req_cancel_busy", {31'd0, u_if.busy}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check("req_cancel_hi", u_if.hi, hold_hi);
        check("req_cancel_lo", u_if.lo, hold_lo);

        // ------- start while busy ignored; req while in flight ignored -------
        @(negedge clk);
        u_if.start = 1'b1; u_if.op = c_OP_DIVU; u_if.rs_data = 32'd100; u_if.rt_data = 32'd7;
        @(posedge clk); #1;
        u_if.start = 1'b0;
        cyc = 0;
        while (u_if.busy && cyc < 200) begin
            @(negedge clk);
            u_if.start   = (cyc == 2);
            u_if.op      = c_OP_MULT;
            u_if.rs_data = 32'h3;
            u_if.rt_data = 32'h3;
            u_if.req     = (cyc == 4);
            @(posedge clk); #1;
            cyc++;
        end
        u_if.start = 1'b0; u_if.req = 1'b0;
        check("busy_start_cycles", 32'(cyc), 32'd10);
        check("busy_start_hi", u_if.hi, 32'h2);
        check("busy_start_lo", u_if.lo, 32'hE);
        repeat (6) @(posedge clk);
        #1;
        check("busy_start_after_busy", {31'd0, u_if.busy}, 32'd0);
        check("busy_start_after_lo", u_if.lo, 32'hE);

        // ---------------- reset mid-operation aborts ----------------
        @(negedge clk);
        u_if.start = 1'b1; u_if.op = c_OP_DIV; u_if.rs_data = 32'hFFFFFFF9; u_if.rt_data = 32'h2;
        @(posedge clk); #1;
        u_if.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, u_if.busy}, 32'd0);
        check("abort_hi", u_if.hi, 32'd0);
        check("abort_lo", u_if.lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        u_if.start = 1'b1; u_if.op = c_OP_MTLO; u_if.rs_data = 32'hAAAA5555;
        @(posedge clk); #1;
        u_if.start = 1'b0;
        check("first_edge_lo", u_if.lo, 32'hAAAA5555);
        check("first_edge_hi", u_if.hi, 32'd0);
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_commit_busy", {31'd0, u_if.busy}, 32'd0);
        check("abort_no_commit_lo", u_if.lo, 32'hAAAA5555);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
